keypad_scan_decoder: RTL and testbench

- Input-side counterpart to the time-multiplexed 7-segment driver: scans a 4x4 matrix hex keypad (Pmod KYPD style) one column at a time, samples rows, debounces, decodes the pressed key to a hex nibble.
- Accepted keys shift into a 16-bit register that can feed the hex2seg/display path in place of SW[15:0].
- Sits between the keypad pins and the display top level; runs on the board clock.

---
 rtl/keypad_scan_decoder_if.sv | 38 +++
 rtl/keypad_scan_decoder.sv | 225 ++++++++++++++++++++++
 tb/tb_keypad_scan_decoder.sv | 273 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/keypad_scan_decoder_if.sv
// keypad_scan_decoder_if
//   Groups the keypad pins and the decoded-key outputs of keypad_scan_decoder.
//   Signals:
//     row       [3:0]  keypad rows, active-low (pulled up)
//     col       [3:0]  keypad column drive, active-low, exactly one bit low
//     key_code  [3:0]  hex value of the last accepted key
//     key_valid        one-cycle pulse when key_code/value update
//     key_held         high while the accepted key remains debounced-pressed
//     value     [15:0] last four accepted keys, newest in [3:0]
//   Modports:
//     master  decoder side (drives col and the key outputs, reads row)
//     slave   keypad/consumer side (drives row, reads the rest)
interface keypad_scan_decoder_if;
    logic [3:0]  row;
    logic [3:0]  col;
    logic [3:0]  key_code;
    logic        key_valid;
    logic        key_held;
    logic [15:0] value;

    modport master (
        input  row,
        output col,
        output key_code,
        output key_valid,
        output key_held,
        output value
    );

    modport slave (
        output row,
        input  col,
        input  key_code,
        input  key_valid,
        input  key_held,
        input  value
    );
endinterface

// File: rtl/keypad_scan_decoder.sv
// keypad_scan_decoder
//   Scans a 4x4 hex keypad one column at a time, samples the synchronized rows on
//   the last cycle of each column slot, classifies every full scan as NONE,
//   SINGLE(code) or MULTI, debounces press and release over DEBOUNCE_SCANS scans
//   and shifts each accepted key into a 16-bit display value.
//   Ports:
//     clk_i    system clock
//     reset_i  synchronous, active-high reset
//     kp       keypad_scan_decoder_if.master (row in; col, key_code, key_valid,
//              key_held, value out)
//   Optional feature: define KEYPAD_REPEAT_EN to auto-repeat a held key after
//   REPEAT_SCANS scans, then every 8 scans. Without it no hold counter exists.
module keypad_scan_decoder #(
    parameter int unsigned SCAN_TICKS     = 50000,
    parameter int unsigned DEBOUNCE_SCANS = 4,
    parameter int unsigned REPEAT_SCANS   = 30
) (
    input logic                   clk_i,
    input logic                   reset_i,
    keypad_scan_decoder_if.master kp
);

    localparam int unsigned TickW = (SCAN_TICKS > 1) ? $clog2(SCAN_TICKS) : 1;
    localparam int unsigned CntW  = $clog2(DEBOUNCE_SCANS + 1);

    // Nibble {col, row} holds the key at that matrix position.
    localparam logic [63:0] KeyMap = 64'hDCBA_E963_F852_0741;

    typedef enum logic [1:0] {StIdle, StPressPend, StPressed, StReleasePend} state_e;

    logic [3:0]       row_meta_q, row_sync_q;
    logic [TickW-1:0] tick_q;
    logic [1:0]       col_idx_q;
    logic [1:0]       acc_lows_q;   // low rows seen so far this scan, saturating at 2
    logic [3:0]       acc_code_q;
    state_e           state_q, state_d;
    logic [3:0]       cand_q, cand_d;
    logic [CntW-1:0]  cnt_q, cnt_d;
    logic [3:0]       key_code_q;
    logic             key_valid_q;
    logic             key_held_q, held_d;
    logic [15:0]      value_q;
    logic             accept;

    logic             slot_end, scan_end;
    logic [1:0]       col_lows, tot_lows;
    logic [2:0]       lows_sum;
    logic [3:0]       col_code, scan_code;
    logic             res_none, res_single;
    logic [CntW-1:0]  cnt_inc;

`ifdef KEYPAD_REPEAT_EN
    localparam int unsigned HoldMax = (REPEAT_SCANS > 8) ? REPEAT_SCANS : 8;
    localparam int unsigned HoldW   = $clog2(HoldMax + 1);

    // After the first repeat the counter restarts from zero with an 8-scan
    // threshold, equivalent to reloading REPEAT_SCANS-8 but never negative.
    logic [HoldW-1:0] hold_q, hold_d, hold_inc;
    logic             rep_phase_q, rep_phase_d;
`endif

    assign slot_end = (tick_q == TickW'(SCAN_TICKS - 1));
    assign scan_end = slot_end && (col_idx_q == 2'd3);

    // Classify the current column and merge with the scan so far.
    always_comb begin
        col_lows = 2'd0;
        col_code = 4'd0;
        for (int r = 0; r < 4; r++) begin
            if (!row_sync_q[r]) begin
                if (col_lows != 2'd2) col_lows = col_lows + 2'd1;
                col_code = KeyMap[{col_idx_q, 2'(r), 2'b00} +: 4];
            end
        end
    end

    assign lows_sum   = {1'b0, acc_lows_q} + {1'b0, col_lows};
    assign tot_lows   = (lows_sum >= 3'd2) ? 2'd2 : lows_sum[1:0];
    assign scan_code  = (col_lows != 2'd0) ? col_code : acc_code_q;
    assign res_none   = (tot_lows == 2'd0);
    assign res_single = (tot_lows == 2'd1);
    assign cnt_inc    = cnt_q + CntW'(1);

    always_comb begin
        state_d = state_q;
        cand_d  = cand_q;
        cnt_d   = cnt_q;
        held_d  = key_held_q;
        accept  = 1'b0;
`ifdef KEYPAD_REPEAT_EN
        hold_d      = hold_q;
        rep_phase_d = rep_phase_q;
        hold_inc    = hold_q + HoldW'(1);
`endif
        if (scan_end) begin
            unique case (state_q)
                StIdle: begin
                    if (res_single) begin
                        cand_d = scan_code;
                        cnt_d  = CntW'(1);
                        if (DEBOUNCE_SCANS <= 1) begin
                            state_d = StPressed;
                            accept  = 1'b1;
                        end else begin
                            state_d = StPressPend;
                        end
                    end
                end
                StPressPend: begin
                    if (res_single && scan_code == cand_q) begin
                        cnt_d = cnt_inc;
                        if (cnt_inc == CntW'(DEBOUNCE_SCANS)) begin
                            state_d = StPressed;
                            accept  = 1'b1;
                        end
                    end else if (res_single) begin
                        cand_d = scan_code;
                        cnt_d  = CntW'(1);
                    end else begin
                        state_d = StIdle;
                    end
                end
                StPressed: begin
                    if (res_none) begin
                        cnt_d = CntW'(1);
                        if (DEBOUNCE_SCANS <= 1) begin
                            state_d = StIdle;
                            held_d  = 1'b0;
                        end else begin
                            state_d = StReleasePend;
                        end
                    end
`ifdef KEYPAD_REPEAT_EN
                    else if (res_single && scan_code == cand_q) begin
                        if (hold_inc == (rep_phase_q ? HoldW'(8) : HoldW'(REPEAT_SCANS))) begin
                            accept      = 1'b1;
                            hold_d      = '0;
                            rep_phase_d = 1'b1;
                        end else begin
                            hold_d = hold_inc;
                        end
                    end
`endif
                end
                StReleasePend: begin
                    if (res_none) begin
                        cnt_d = cnt_inc;
                        if (cnt_inc == CntW'(DEBOUNCE_SCANS)) begin
                            state_d = StIdle;
                            held_d  = 1'b0;
                        end
                    end else begin
                        state_d = StPressed;
                    end
                end
                default: state_d = StIdle;
            endcase
        end
        if (accept) held_d = 1'b1;
`ifdef KEYPAD_REPEAT_EN
        if (state_d != StPressed) begin
            hold_d      = '0;
            rep_phase_d = 1'b0;
        end
`endif
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            row_meta_q  <= 4'hF;
            row_sync_q  <= 4'hF;
            tick_q      <= '0;
            col_idx_q   <= 2'd0;
            acc_lows_q  <= 2'd0;
            acc_code_q  <= 4'd0;
            state_q     <= StIdle;
            cand_q      <= 4'd0;
            cnt_q       <= '0;
            key_code_q  <= 4'd0;
            key_valid_q <= 1'b0;
            key_held_q  <= 1'b0;
            value_q     <= 16'h0000;
        end else begin
            row_meta_q <= kp.row;
            row_sync_q <= row_meta_q;
            if (slot_end) begin
                tick_q    <= '0;
                col_idx_q <= col_idx_q + 2'd1;
                // Clear on scan end so the next scan starts empty.
                acc_lows_q <= scan_end ? 2'd0 : tot_lows;
                acc_code_q <= scan_end ? 4'd0 : scan_code;
            end else begin
                tick_q <= tick_q + TickW'(1);
            end
            state_q     <= state_d;
            cand_q      <= cand_d;
            cnt_q       <= cnt_d;
            key_held_q  <= held_d;
            key_valid_q <= accept;
            if (accept) begin
                key_code_q <= cand_d;
                value_q    <= {value_q[11:0], cand_d};
            end
        end
    end

`ifdef KEYPAD_REPEAT_EN
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            hold_q      <= '0;
            rep_phase_q <= 1'b0;
        end else begin
            hold_q      <= hold_d;
            rep_phase_q <= rep_phase_d;
        end
    end
`endif

    assign kp.col       = ~(4'b0001 << col_idx_q);
    assign kp.key_code  = key_code_q;
    assign kp.key_valid = key_valid_q;
    assign kp.key_held  = key_held_q;
    assign kp.value     = value_q;

endmodule

// File: tb/tb_keypad_scan_decoder.sv
// tb_keypad_scan_decoder
//   Drives the keypad rows from a set of pressed keys (one whole scan at a time),
//   predicts accepted keys with a scan-level model and checks every key_valid
//   pulse (cycle, key_code, value) from a scoreboard queue, plus col every cycle
//   and key_held after every scan.
module tb_keypad_scan_decoder;

    localparam int unsigned ST = 4;
    localparam int unsigned DB = 2;
    localparam int unsigned RP = 6;
    localparam int          ScanCyc = 4 * ST;

    localparam int MIdle = 0, MPend = 1, MPressed = 2, MRel = 3;

    typedef struct {
        int          cyc;
        logic [3:0]  code;
        logic [15:0] value;
    } exp_t;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [15:0] mask = 16'h0000;
    logic [3:0]  row_drv;
    int          cyc = 0;
    int          checks = 0;
    int          errors = 0;
    exp_t        sb[$];
    exp_t        mon_e;

    int keymap[4][4] = '{'{1, 4, 7, 0}, '{2, 5, 8, 15}, '{3, 6, 9, 14}, '{10, 11, 12, 13}};

    // Reference model state
    int          mst = MIdle;
    int          mcand = 0;
    int          mcnt = 0;
    int          mhold = 0;
    bit          mheld = 1'b0;
    logic [15:0] mvalue = 16'h0000;

    always #5 clk = ~clk;

    keypad_scan_decoder_if kif ();

    keypad_scan_decoder #(
        .SCAN_TICKS    (ST),
        .DEBOUNCE_SCANS(DB),
        .REPEAT_SCANS  (RP)
    ) dut (
        .clk_i  (clk),
        .reset_i(reset),
        .kp     (kif)
    );

    // A row reads low when a pressed key sits at (driven column, row).
    always_comb begin
        row_drv = 4'hF;
        for (int c = 0; c < 4; c++)
            for (int r = 0; r < 4; r++)
                if (!kif.col[c] && mask[keymap[c][r]]) row_drv[r] = 1'b0;
    end
    assign kif.row = row_drv;

    always @(posedge clk) begin
        if (reset) cyc <= 0;
        else       cyc <= cyc + 1;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic logic [3:0] exp_col(input int c);
        logic [3:0] v;
        v = 4'hF;
        v[(c / ScanCyc * 0) + (c / int'(ST)) % 4] = 1'b0;
        return v;
    endfunction

    function automatic logic [15:0] key(input int k);
        logic [15:0] one;
        one = 16'h0001;
        return one << k;
    endfunction

    // One full scan's worth of the debounce rules, applied to the set of pressed keys.
    task automatic model_scan(input logic [15:0] m, input int end_cyc);
        int n;
        int k;
        bit acc;
        n   = $countones(m);
        k   = -1;
        acc = 1'b0;
        for (int i = 0; i < 16; i++) if (m[i]) k = i;
        case (mst)
            MIdle: if (n == 1) begin mcand = k; mcnt = 1; mst = MPend; end
            MPend: begin
                if (n == 1 && k == mcand) mcnt++;
                else if (n == 1) begin mcand = k; mcnt = 1; end
                else mst = MIdle;
            end
            MPressed: begin
                if (n == 0) begin
                    mst   = MRel;
                    mcnt  = 1;
                    mhold = 0;
                end else if (n == 1 && k == mcand) begin
`ifdef KEYPAD_REPEAT_EN
                    mhold++;
                    if (mhold == RP || (mhold > RP && (mhold - RP) % 8 == 0)) acc = 1'b1;
`endif
                end
            end
            default: begin
                if (n == 0) mcnt++;
                else mst = MPressed;
            end
        endcase
        if (mst == MPend && mcnt >= DB) begin
            mst   = MPressed;
            mhold = 0;
            acc   = 1'b1;
        end
        if (mst == MRel && mcnt >= DB) mst = MIdle;
        mheld = (mst == MPressed || mst == MRel);
        if (acc) begin
            mvalue = {mvalue[11:0], 4'(mcand)};
            sb.push_back('{end_cyc + 1, 4'(mcand), mvalue});
        end
    endtask

    task automatic run_scan(input logic [15:0] m);
        mask = m;
        model_scan(m, cyc + ScanCyc - 1);
        repeat (ScanCyc) @(posedge clk);
        #1;
        check("key_held", kif.key_held, mheld);
    endtask

    task automatic run_many(input logic [15:0] m, input int n);
        for (int i = 0; i < n; i++) run_scan(m);
    endtask

    task automatic do_reset();
        reset = 1'b1;
        @(posedge clk);
        #1;
        check("reset_col", kif.col, 4'b1110);
        check("reset_key_code", kif.key_code, 4'h0);
        check("reset_key_valid", kif.key_valid, 1'b0);
        check("reset_key_held", kif.key_held, 1'b0);
        check("reset_value", kif.value, 16'h0000);
        mst    = MIdle;
        mcnt   = 0;
        mhold  = 0;
        mheld  = 1'b0;
        mvalue = 16'h0000;
        sb.delete();
        reset = 1'b0;
    endtask

    // Monitor: column drive every cycle, and every key pulse against the scoreboard.
    always @(negedge clk) begin
        if (!reset) begin
            check("col", kif.col, exp_col(cyc));
            if (kif.key_valid) begin
                if (sb.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_pulse got key_code %0h value %0h at cycle %0d, expected no pulse",
                             kif.key_code, kif.value, cyc);
                end else begin
                    mon_e = sb.pop_front();
                    check("pulse_cycle", cyc, mon_e.cyc);
                    check("pulse_key_code", kif.key_code, mon_e.code);
                    check("pulse_value", kif.value, mon_e.value);
                end
            end
        end
    end

    initial begin
        logic [15:0] rm;
        int          sel;
        int          a;
        int          b;

        mask = 16'h0000;
        do_reset();

        // Idle keypad: no pulses, value stays zero.
        run_many(16'h0000, 3);
        check("idle_value", kif.value, 16'h0000);

        // Key 5 held then released.
        run_many(key(5), 4);
        check("key5_value", kif.value, 16'h0005);
        check("key5_code", kif.key_code, 4'h5);
        run_many(16'h0000, 4);

        // 1,2,3,A each held 3 scans and released 3 scans.
        run_many(key(1), 3);  run_many(16'h0000, 3);
        run_many(key(2), 3);  run_many(16'h0000, 3);
        run_many(key(3), 3);  run_many(16'h0000, 3);
        run_many(key(10), 3); run_many(16'h0000, 3);
        check("seq_value", kif.value, 16'h123A);

        // Two keys together from idle, then a second key added while one is held.
        run_many(key(1) | key(2), 3);
        run_many(16'h0000, 3);
        run_many(key(5), 3);
        run_many(key(5) | key(4), 3);
        run_many(16'h0000, 3);
        check("multi_value", kif.value, 16'h23A5);

        // Bouncing 7 settles into one press.
        for (int i = 0; i < 5; i++) run_scan((i % 2 == 0) ? key(7) : 16'h0000);
        run_many(key(7), 4);
        check("bounce_code", kif.key_code, 4'h7);
        run_many(16'h0000, 3);

        // Long hold of F (repeats only with KEYPAD_REPEAT_EN).
        run_many(key(15), 30);
        check("hold_value", kif.value, mvalue);
        run_many(16'h0000, 3);

        // Random key activity.
        rm = 16'h0000;
        for (int i = 0; i < 60; i++) begin
            if ($urandom_range(0, 1) == 0) begin
                sel = int'($urandom_range(0, 9));
                if (sel < 4) begin
                    rm = 16'h0000;
                end else if (sel < 9) begin
                    rm = key(int'($urandom_range(0, 15)));
                end else begin
                    a  = int'($urandom_range(0, 15));
                    b  = (a + 1 + int'($urandom_range(0, 14))) % 16;
                    rm = key(a) | key(b);
                end
            end
            run_scan(rm);
        end
        check("random_value", kif.value, mvalue);
        check("random_key_held", kif.key_held, mheld);

        // Reset in the middle of a pending press.
        run_many(16'h0000, 3);
        run_scan(key(9));
        repeat (6) @(posedge clk);
        #1;
        do_reset();

        // Normal operation resumes after reset.
        run_many(16'h0000, 2);
        run_many(key(12), 4);
        run_many(16'h0000, 3);
        check("post_reset_value", kif.value, 16'h000C);
        check("post_reset_code", kif.key_code, 4'hC);

        repeat (4) @(posedge clk);
        #1;
        check("pending_pulses", sb.size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
